// File: rtl/rs_cd_pkg.sv
// ---------------------------------------------------------------------------
// rs_cd_pkg
// Shared types and GF(256) helpers for the CD CIRC Reed-Solomon decoder.
//   status_e   : result codes reported by the C1 correction controller
//   state_e    : sequencing states of rs_c1_corr_ctrl
//   GF_ALPHA   : primitive element alpha = x
//   GF_PRIM_LO : low byte of x^8+x^4+x^3+x^2+1
//   gf256_mul  : combinational shift-and-reduce GF(256) multiply
// ---------------------------------------------------------------------------
package rs_cd_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_CORR = 2'd1,
    ST_FAIL = 2'd2
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ZCHK,
    S_INV,
    S_LOC,
    S_VERIFY,
    S_SEARCH,
    S_DONE
  } state_e;

  localparam logic [7:0] GF_ALPHA   = 8'h02;
  localparam logic [7:0] GF_PRIM_LO = 8'h1D;

  // Walks the bits of b, accumulating a*x^i while a is multiplied by x
  // (shift, then fold bit 8 back in with the reduction byte).
  function automatic logic [7:0] gf256_mul(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic [7:0] prim_lo);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? prim_lo : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/gf256_mul_alpha.sv
// ---------------------------------------------------------------------------
// gf256_mul_alpha
// Combinational multiply by alpha (= x) in GF(256); steps the locator
// search candidate one power of alpha per cycle.
//   i_a : operand
//   o_y : i_a * alpha
// ---------------------------------------------------------------------------
module gf256_mul_alpha
  import rs_cd_pkg::*;
#(
  parameter logic [7:0] PRIM_LO = GF_PRIM_LO
) (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);

  assign o_y = {i_a[6:0], 1'b0} ^ (i_a[7] ? PRIM_LO : 8'h00);

endmodule

// File: rtl/rs_c1_corr_ctrl.sv
// ---------------------------------------------------------------------------
// rs_c1_corr_ctrl
// Single-error correction sequencer for the CIRC C1 stage, RS(32,28).
// Classifies the four syndromes as no error / one error / uncorrectable,
// obtains 1/S0 from a shared gf256_inv via req/gnt, forms the locator
// X = S1/S0, verifies it against S2 and S3, then searches alpha^k == X.
//
// Ports:
//   i_clk, i_resb           clock, asynchronous active-low reset
//   i_syn_valid, i_s0..i_s3 one-cycle syndrome strobe and syndromes
//   o_inv_req, i_inv_gnt    shared-inverter handshake
//   o_inv_x, i_inv_y        inverter operand (S0 while requesting) / result
//   o_valid                 one-cycle result strobe
//   o_status                0 none, 1 corrected, 2 uncorrectable
//   o_err_pos, o_err_mag    error position / magnitude (held until next result)
//   o_busy                  state is not IDLE
//   o_overrun               sticky: syndromes arrived while busy
//
// Build option RS_C1_CORR_STATS_EN adds saturating o_cnt_corr / o_cnt_fail.
// ---------------------------------------------------------------------------
module rs_c1_corr_ctrl
  import rs_cd_pkg::*;
#(
  parameter  int         N_SYM   = 32,
  parameter  logic [7:0] PRIM_LO = GF_PRIM_LO,
  localparam int         POS_W   = $clog2(N_SYM)
) (
  input  logic             i_clk,
  input  logic             i_resb,
  input  logic             i_syn_valid,
  input  logic [7:0]       i_s0,
  input  logic [7:0]       i_s1,
  input  logic [7:0]       i_s2,
  input  logic [7:0]       i_s3,
  output logic             o_inv_req,
  input  logic             i_inv_gnt,
  output logic [7:0]       o_inv_x,
  input  logic [7:0]       i_inv_y,
  output logic             o_valid,
  output logic [1:0]       o_status,
  output logic [POS_W-1:0] o_err_pos,
  output logic [7:0]       o_err_mag,
  output logic             o_busy,
`ifdef RS_C1_CORR_STATS_EN
  output logic [15:0]      o_cnt_corr,
  output logic [15:0]      o_cnt_fail,
`endif
  output logic             o_overrun
);

  localparam logic [POS_W-1:0] K_LAST = POS_W'(N_SYM - 1);

  state_e           state_q, state_d;
  logic [7:0]       s0_q, s1_q, s2_q, s3_q;
  logic [7:0]       s0_d, s1_d, s2_d, s3_d;
  logic [7:0]       invr_q, invr_d;
  logic [7:0]       x_q, x_d;
  logic [7:0]       p_q, p_d, p_next;
  logic [POS_W-1:0] k_q, k_d;
  // Result decided on entry to DONE; published to the outputs on leaving it.
  status_e          res_st_q, res_st_d;
  logic [POS_W-1:0] res_pos_q, res_pos_d;
  logic [7:0]       res_mag_q, res_mag_d;
  logic             valid_q, valid_d;
  logic [1:0]       status_q, status_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [7:0]       mag_q, mag_d;
  logic             overrun_q, overrun_d;

  gf256_mul_alpha #(.PRIM_LO(PRIM_LO)) u_step (
    .i_a (p_q),
    .o_y (p_next)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    s0_d      = s0_q;
    s1_d      = s1_q;
    s2_d      = s2_q;
    s3_d      = s3_q;
    invr_d    = invr_q;
    x_d       = x_q;
    p_d       = p_q;
    k_d       = k_q;
    res_st_d  = res_st_q;
    res_pos_d = res_pos_q;
    res_mag_d = res_mag_q;
    valid_d   = 1'b0;
    status_d  = status_q;
    pos_d     = pos_q;
    mag_d     = mag_q;
    // DONE counts as busy, so only IDLE accepts new syndromes.
    overrun_d = overrun_q | (i_syn_valid && (state_q != S_IDLE));

    unique case (state_q)
      S_IDLE: begin
        if (i_syn_valid) begin
          s0_d    = i_s0;
          s1_d    = i_s1;
          s2_d    = i_s2;
          s3_d    = i_s3;
          state_d = S_ZCHK;
        end
      end
      S_ZCHK: begin
        res_pos_d = '0;
        res_mag_d = '0;
        if ((s0_q | s1_q | s2_q | s3_q) == 8'h00) begin
          res_st_d = ST_NONE;
          state_d  = S_DONE;
        end else if (s0_q == 8'h00) begin
          res_st_d = ST_FAIL;
          state_d  = S_DONE;
        end else begin
          state_d  = S_INV;
        end
      end
      S_INV: begin
        if (i_inv_gnt) begin
          invr_d  = i_inv_y;
          state_d = S_LOC;
        end
      end
      S_LOC: begin
        x_d     = gf256_mul(s1_q, invr_q, PRIM_LO);
        state_d = S_VERIFY;
      end
      S_VERIFY: begin
        // A single error makes the syndromes a geometric series of ratio X.
        if ((gf256_mul(s1_q, x_q, PRIM_LO) == s2_q) &&
            (gf256_mul(s2_q, x_q, PRIM_LO) == s3_q)) begin
          p_d     = 8'h01;
          k_d     = '0;
          state_d = S_SEARCH;
        end else begin
          res_st_d = ST_FAIL;
          state_d  = S_DONE;
        end
      end
      S_SEARCH: begin
        if (p_q == x_q) begin
          res_st_d  = ST_CORR;
          res_pos_d = k_q;
          res_mag_d = s0_q;
          state_d   = S_DONE;
        end else if (k_q == K_LAST) begin
          res_st_d = ST_FAIL;
          state_d  = S_DONE;
        end else begin
          p_d = p_next;
          k_d = k_q + POS_W'(1);
        end
      end
      S_DONE: begin
        valid_d  = 1'b1;
        status_d = res_st_q;
        pos_d    = res_pos_q;
        mag_d    = res_mag_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      state_q   <= S_IDLE;
      s0_q      <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      invr_q    <= '0;
      x_q       <= '0;
      p_q       <= '0;
      k_q       <= '0;
      res_st_q  <= ST_NONE;
      res_pos_q <= '0;
      res_mag_q <= '0;
      valid_q   <= 1'b0;
      status_q  <= '0;
      pos_q     <= '0;
      mag_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from
      // pre-edge values, independent of statement order.
      state_q   <= state_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      invr_q    <= invr_d;
      x_q       <= x_d;
      p_q       <= p_d;
      k_q       <= k_d;
      res_st_q  <= res_st_d;
      res_pos_q <= res_pos_d;
      res_mag_q <= res_mag_d;
      valid_q   <= valid_d;
      status_q  <= status_d;
      pos_q     <= pos_d;
      mag_q     <= mag_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef RS_C1_CORR_STATS_EN
  logic [15:0] cnt_corr_q, cnt_fail_q;

  always_ff @(posedge i_clk or negedge i_resb) begin
    if (!i_resb) begin
      cnt_corr_q <= '0;
      cnt_fail_q <= '0;
    end else if (state_q == S_DONE) begin
      if ((res_st_q == ST_CORR) && (cnt_corr_q != 16'hFFFF)) cnt_corr_q <= cnt_corr_q + 16'd1;
      if ((res_st_q == ST_FAIL) && (cnt_fail_q != 16'hFFFF)) cnt_fail_q <= cnt_fail_q + 16'd1;
    end
  end

  assign o_cnt_corr = cnt_corr_q;
  assign o_cnt_fail = cnt_fail_q;
`endif

  assign o_inv_req = (state_q == S_INV);
  assign o_inv_x   = o_inv_req ? s0_q : 8'h00;
  assign o_valid   = valid_q;
  assign o_status  = status_q;
  assign o_err_pos = pos_q;
  assign o_err_mag = mag_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_overrun = overrun_q;

endmodule

// File: tb/tb_rs_c1_corr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rs_c1_corr_ctrl
// Self-checking bench for rs_c1_corr_ctrl. Expected results and their due
// cycle are queued when syndromes are issued and compared when o_valid
// rises. The shared inverter is modelled by exhaustive search.
// ---------------------------------------------------------------------------
module tb_rs_c1_corr_ctrl;

  localparam int N_SYM = 32;
  localparam int POS_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             syn_valid = 1'b0;
  logic [7:0]       s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  logic             inv_req;
  logic             inv_gnt = 1'b1;
  logic [7:0]       inv_x;
  logic [7:0]       inv_y;
  logic             o_valid;
  logic [1:0]       o_status;
  logic [POS_W-1:0] o_err_pos;
  logic [7:0]       o_err_mag;
  logic             o_busy;
  logic             o_overrun;
`ifdef RS_C1_CORR_STATS_EN
  logic [15:0]      cnt_corr, cnt_fail;
`endif

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic [4:0] pos;
    logic [7:0] mag;
    int         due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   stall_left = 0;
  logic [7:0] exp_inv_x = '0;
  logic seen_req = 1'b0;

  always #5 clk = ~clk;

  rs_c1_corr_ctrl #(.N_SYM(N_SYM), .PRIM_LO(8'h1D)) dut (
    .i_clk       (clk),
    .i_resb      (rst_n),
    .i_syn_valid (syn_valid),
    .i_s0        (s0),
    .i_s1        (s1),
    .i_s2        (s2),
    .i_s3        (s3),
    .o_inv_req   (inv_req),
    .i_inv_gnt   (inv_gnt),
    .o_inv_x     (inv_x),
    .i_inv_y     (inv_y),
    .o_valid     (o_valid),
    .o_status    (o_status),
    .o_err_pos   (o_err_pos),
    .o_err_mag   (o_err_mag),
    .o_busy      (o_busy),
`ifdef RS_C1_CORR_STATS_EN
    .o_cnt_corr  (cnt_corr),
    .o_cnt_fail  (cnt_fail),
`endif
    .o_overrun   (o_overrun)
  );

  // Carry-less product then polynomial reduction by 0x11D, high bits first.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (acc[i]) acc = acc ^ (15'h11D << (i - 8));
    return acc[7:0];
  endfunction

  function automatic logic [7:0] apow(input int n);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < n; i++) r = gmul(r, 8'h02);
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] x);
    for (int b = 1; b < 256; b++) if (gmul(x, 8'(b)) == 8'h01) return 8'(b);
    return 8'h00;
  endfunction

  assign inv_y = ginv(inv_x);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // Grant driver: holds gnt low for stall_left requesting cycles.
  always @(negedge clk) begin
    if (inv_req) begin
      seen_req = 1'b1;
      check("inv_x", inv_x, exp_inv_x);
      if (stall_left > 0) begin
        inv_gnt = 1'b0;
        stall_left--;
      end else begin
        inv_gnt = 1'b1;
      end
    end else begin
      inv_gnt = 1'b1;
    end
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    exp_t e;
    if (o_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check({e.tag, "_status"}, o_status, e.st);
        check({e.tag, "_pos"},    o_err_pos, e.pos);
        check({e.tag, "_mag"},    o_err_mag, e.mag);
        check({e.tag, "_cycle"},  cyc, e.due);
      end
    end
  end

  // lat is the edge number after which o_valid is expected, gnt held high.
  task automatic issue(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input logic [1:0] st,
                       input logic [4:0] pos, input logic [7:0] mag, input int lat,
                       input int stall, input bit push);
    exp_t e;
    @(negedge clk);
    if (push) begin
      e.tag = tag; e.st = st; e.pos = pos; e.mag = mag;
      e.due = cyc + 1 + lat + stall;
      sb.push_back(e);
    end
    stall_left = stall;
    exp_inv_x  = a;
    syn_valid  = 1'b1;
    s0 = a; s1 = b; s2 = c; s3 = d;
    @(negedge clk);
    syn_valid = 1'b0;
  endtask

  task automatic issue_err(input string tag, input logic [7:0] e, input int i,
                           input int stall);
    issue(tag, e, gmul(e, apow(i)), gmul(e, apow(2 * i)), gmul(e, apow(3 * i)),
          2'd1, 5'(i), e, 6 + i, stall, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check({tag, "_timeout"}, 0, 1);
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid",  o_valid,  0);
    check("rst_status", o_status, 0);
    check("rst_busy",   o_busy,   0);
    check("rst_inv_req", inv_req, 0);
    rst_n = 1'b1;
    @(negedge clk);

    seen_req = 1'b0;
    issue("zero", 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 5'd0, 8'h00, 2, 0, 1'b1);
    wait_idle("zero");
    check("zero_no_req", seen_req, 0);

    issue("corr_i1", 8'h05, 8'h0A, 8'h14, 8'h28, 2'd1, 5'd1, 8'h05, 7, 0, 1'b1);
    wait_idle("corr_i1");
    repeat (4) @(negedge clk);
    check("hold_status", o_status, 1);
    check("hold_pos", o_err_pos, 1);

    issue("corr_i3_stall", 8'h01, 8'h08, 8'h40, 8'h3A, 2'd1, 5'd3, 8'h01, 9, 3, 1'b1);
    wait_idle("corr_i3_stall");

    issue("verify_fail", 8'h01, 8'h02, 8'h04, 8'h09, 2'd2, 5'd0, 8'h00, 5, 0, 1'b1);
    wait_idle("verify_fail");

    issue("s0_zero", 8'h00, 8'h05, 8'h00, 8'h00, 2'd2, 5'd0, 8'h00, 2, 0, 1'b1);
    wait_idle("s0_zero");

    issue("search_fail", 8'h01, apow(40), apow(80), apow(120), 2'd2, 5'd0, 8'h00,
          5 + N_SYM, 0, 1'b1);
    wait_idle("search_fail");

    issue_err("corr_i0", 8'h80, 0, 0);
    wait_idle("corr_i0");
    issue_err("corr_i31", 8'hC7, 31, 1);
    wait_idle("corr_i31");

    // Syndromes arriving mid-search are dropped and flagged.
    check("ovr_before", o_overrun, 0);
    issue_err("ovr_run", 8'h33, 20, 0);
    repeat (8) @(negedge clk);
    check("ovr_busy", o_busy, 1);
    syn_valid = 1'b1;
    s0 = 8'h00; s1 = 8'h00; s2 = 8'h00; s3 = 8'h00;
    @(negedge clk);
    syn_valid = 1'b0;
    check("ovr_set", o_overrun, 1);
    wait_idle("ovr_run");
    check("ovr_sticky", o_overrun, 1);

    // Reset at edge 6 of a search-fail run: nothing may be emitted.
    issue("rst_mid", 8'h01, apow(40), apow(80), apow(120), 2'd2, 5'd0, 8'h00,
          5 + N_SYM, 0, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_valid",   o_valid,   0);
    check("mid_status",  o_status,  0);
    check("mid_pos",     o_err_pos, 0);
    check("mid_mag",     o_err_mag, 0);
    check("mid_busy",    o_busy,    0);
    check("mid_overrun", o_overrun, 0);
    check("mid_inv_x",   inv_x,     0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_idle", o_busy, 0);

    issue_err("post_rst", 8'h9E, 12, 2);
    wait_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
